// File: rtl/neuron_net_pkg.sv
// neuron_net_pkg: shared class count and decoder state encoding
package neuron_net_pkg;
  localparam int N_CLASSES = 10;
  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;
endpackage

// File: rtl/spike_counter_bank.sv
// spike_counter_bank: per-class saturating spike counters with sticky saturation flag
module spike_counter_bank #(
  parameter int N_CLASSES = neuron_net_pkg::N_CLASSES,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic [N_CLASSES-1:0]         inc,
  output logic [N_CLASSES*CNT_W-1:0]   counts,
  output logic                         saturated
);
  logic [CNT_W-1:0] cnt [N_CLASSES];
  logic [N_CLASSES-1:0] hit;
  for (genvar g = 0; g < N_CLASSES; g++) begin : g_cnt
    assign hit[g] = inc[g] && (&cnt[g]);
    assign counts[g*CNT_W +: CNT_W] = cnt[g];
  end
  // count each requested spike, holding at all-ones and flagging attempts beyond it
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '{default: '0};
      saturated <= 1'b0;
    end else begin
      for (int i = 0; i < N_CLASSES; i++)
        if (inc[i] && !hit[i]) cnt[i] <= cnt[i] + 1'b1;
      if (|hit) saturated <= 1'b1;
    end
  end
endmodule

// File: rtl/spike_rate_classifier.sv
// spike_rate_classifier: windowed per-class spike counting with sequential argmax result
module spike_rate_classifier #(
  parameter int N_CLASSES = neuron_net_pkg::N_CLASSES,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  parameter int CLS_W = $clog2(N_CLASSES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIN_W-1:0]     window_len,
  input  logic                 spikes_valid,
  input  logic [N_CLASSES-1:0] spikes,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [CLS_W-1:0]     result_class,
  output logic [CNT_W-1:0]     result_count,
  output logic                 result_tie,
  output logic                 saturated
);
  import neuron_net_pkg::*;
  localparam logic [CLS_W-1:0] LAST = CLS_W'(N_CLASSES - 1);
  state_t state;
  logic [WIN_W-1:0] win_rem;
  logic [CLS_W-1:0] idx;
  logic [N_CLASSES*CNT_W-1:0] counts;
  logic [CNT_W-1:0] cur;
  logic clr;
  logic [N_CLASSES-1:0] inc;
  assign clr = state == IDLE && start;
  assign inc = (state == ACCUM && spikes_valid) ? spikes : '0;
  assign cur = counts[idx*CNT_W +: CNT_W];
  assign busy = state != IDLE;
  spike_counter_bank #(.N_CLASSES(N_CLASSES), .CNT_W(CNT_W)) u_bank (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .inc(inc),
    .counts(counts),
    .saturated(saturated)
  );
  // window control plus one-class-per-cycle argmax; the running best lives in the result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      win_rem <= '0;
      idx <= '0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_count <= '0;
      result_tie <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          win_rem <= window_len;
          idx <= '0;
          state <= (window_len == '0) ? SCAN : ACCUM;
        end
        ACCUM: if (spikes_valid) begin
          win_rem <= win_rem - 1'b1;
          if (win_rem == WIN_W'(1)) state <= SCAN;
        end
        SCAN: begin
          idx <= idx + 1'b1;
          if (idx == '0 || cur > result_count) begin
            result_count <= cur;
            result_class <= idx;
            result_tie <= 1'b0;
          end else if (cur == result_count) result_tie <= 1'b1;
          if (idx == LAST) begin
            state <= DONE;
            result_valid <= 1'b1;
          end
        end
        DONE: if (result_ready) begin
          state <= IDLE;
          result_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
